// File: rtl/rvc_fetch_align_pkg.sv
// rtl/rvc_fetch_align_pkg.sv - shared fetch state encoding, NOP and RVC length test
package rvc_fetch_align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    // A parcel is compressed unless its two lsbs are both set
    function automatic logic is_rvc(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/rvc_fetch_align.sv
// rtl/rvc_fetch_align.sv - halfword-aligned fetch with one-word line buffer and straddle handling
module rvc_fetch_align
    import rvc_fetch_align_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        core_stall,
    output logic [31:0] inst,
    output logic        inst_is_c,
    output logic        ic_read,
    output logic [29:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_stall
);

    fetch_state_e state, state_nxt;

    logic        buf_valid;
    logic [29:0] buf_addr;
    logic [31:0] buf_data;
    logic [15:0] hold_lo;

    logic [29:0] pc_word;
    logic        hit;
    logic [31:0] word_src;
    logic        src_avail;
    logic [15:0] half;
    logic        half_is_c;
    logic        save_hold;
    logic        accept;

    assign pc_word   = fetch_pc[31:2];
    // flush must kill a hit in the same cycle so stale code is never issued
    assign hit       = buf_valid & ~flush & (buf_addr == pc_word);
    assign word_src  = hit ? buf_data : ic_rdata;
    assign src_avail = hit | ~ic_stall;
    assign half      = fetch_pc[1] ? word_src[31:16] : word_src[15:0];
    assign half_is_c = is_rvc(half[1:0]);
    assign accept    = ic_read & ~ic_stall;

    // Fetch sequencing and output selection
    always_comb begin
        state_nxt  = state;
        core_stall = 1'b1;
        inst       = NOP_INST;
        inst_is_c  = 1'b0;
        ic_read    = 1'b0;
        ic_addr    = '0;
        save_hold  = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FIRST;
            end
            ST_FIRST: begin
                if (!fetch_en) begin
                    core_stall = 1'b0;
                end else begin
                    ic_read = ~hit;
                    ic_addr = pc_word;
                    if (src_avail) begin
                        if (fetch_pc[1] && !half_is_c) begin
                            // 32-bit instruction crosses into the next word
                            save_hold = 1'b1;
                            state_nxt = ST_SECOND;
                        end else begin
                            core_stall = 1'b0;
                            inst_is_c  = half_is_c;
                            if (!fetch_pc[1] && !half_is_c) begin
                                inst = word_src;
                            end else begin
                                inst = {16'b0, half};
                            end
                        end
                    end
                end
            end
            ST_SECOND: begin
                // Upper half always comes from the cache, never the buffer
                ic_read = 1'b1;
                ic_addr = pc_word + 30'd1;
                if (!ic_stall) begin
                    core_stall = 1'b0;
                    inst       = {ic_rdata[15:0], hold_lo};
                    state_nxt  = ST_FIRST;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Line buffer: a fresh cache word wins over a same-cycle flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (accept) begin
            buf_valid <= 1'b1;
            buf_addr  <= ic_addr;
            buf_data  <= ic_rdata;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end
    end

    // Low half of a straddling instruction, captured on leaving FIRST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_lo <= '0;
        end else if (save_hold) begin
            hold_lo <= half;
        end
    end

endmodule

// File: tb/tb_rvc_fetch_align.sv
// tb/tb_rvc_fetch_align.sv - table-driven and sequence checks for rvc_fetch_align
module tb_rvc_fetch_align;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        core_stall;
    logic [31:0] inst;
    logic        inst_is_c;
    logic        ic_read;
    logic [29:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_stall;

    int checks;
    int failures;

    rvc_fetch_align #(.NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .fetch_pc   (fetch_pc),
        .flush      (flush),
        .core_stall (core_stall),
        .inst       (inst),
        .inst_is_c  (inst_is_c),
        .ic_read    (ic_read),
        .ic_addr    (ic_addr),
        .ic_rdata   (ic_rdata),
        .ic_stall   (ic_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic [31:0] rd;
        logic        ics;
        logic        fl;
        logic        e_stall;
        logic        e_read;
        logic [29:0] e_addr;
        logic [31:0] e_inst;
        logic        e_c;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] pc, input logic [31:0] rd,
                         input logic ics, input logic fl);
        fetch_en = en;
        fetch_pc = pc;
        ic_rdata = rd;
        ic_stall = ics;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //       en   pc            rdata         ics  fl   stall read addr        inst          c
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 30'h0,  NOP,          1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0100, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 30'h40, NOP,          1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0100, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 30'h40, NOP,          1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0100, 32'h0041_4501,1'b0, 1'b0, 1'b0, 1'b1, 30'h40, 32'h0000_4501,1'b1};
        vecs[4]  = '{1'b1, 32'h0000_0102, 32'hDEAD_BEEF,1'b1, 1'b0, 1'b0, 1'b0, 30'h0,  32'h0000_0041,1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0200, 32'h0051_0513,1'b0, 1'b0, 1'b0, 1'b1, 30'h80, 32'h0051_0513,1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0200, 32'hDEAD_BEEF,1'b1, 1'b0, 1'b0, 1'b0, 30'h0,  32'h0051_0513,1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0200, 32'hDEAD_BEEF,1'b1, 1'b1, 1'b1, 1'b1, 30'h80, NOP,          1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0200, 32'hDEAD_BEEF,1'b1, 1'b0, 1'b1, 1'b1, 30'h80, NOP,          1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0100, 32'h0041_4501,1'b0, 1'b0, 1'b0, 1'b1, 30'h40, 32'h0000_4501,1'b1};
        vecs[10] = '{1'b1, 32'h0000_0100, 32'h1234_5679,1'b0, 1'b1, 1'b0, 1'b1, 30'h40, 32'h0000_5679,1'b1};
        vecs[11] = '{1'b1, 32'h0000_0102, 32'hDEAD_BEEF,1'b1, 1'b0, 1'b0, 1'b0, 30'h0,  32'h0000_1234,1'b1};
        vecs[12] = '{1'b1, 32'h0000_00FC, 32'hFFFF_0002,1'b0, 1'b0, 1'b0, 1'b1, 30'h3F, 32'h0000_0002,1'b1};

        rst_n = 1'b0;
        drive(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 1'b0, 1'b0);
        #2;
        chk("reset core_stall", {31'b0, core_stall}, 32'd1);
        chk("reset ic_read", {31'b0, ic_read}, 32'd0);
        chk("reset ic_addr", {2'b0, ic_addr}, 32'd0);
        chk("reset inst", inst, NOP);
        chk("reset inst_is_c", {31'b0, inst_is_c}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle core_stall", {31'b0, core_stall}, 32'd1);
        chk("idle ic_read", {31'b0, ic_read}, 32'd0);
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].pc, vecs[i].rd, vecs[i].ics, vecs[i].fl);
            #3;
            chk($sformatf("vec%0d core_stall", i), {31'b0, core_stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("vec%0d ic_read", i), {31'b0, ic_read}, {31'b0, vecs[i].e_read});
            if (vecs[i].e_read)
                chk($sformatf("vec%0d ic_addr", i), {2'b0, ic_addr}, {2'b0, vecs[i].e_addr});
            chk($sformatf("vec%0d inst", i), inst, vecs[i].e_inst);
            chk($sformatf("vec%0d inst_is_c", i), {31'b0, inst_is_c}, {31'b0, vecs[i].e_c});
            tick();
        end

        // Straddle at 0x302 from the cache, second word stalls once
        drive(1'b1, 32'h0000_0302, 32'h0513_ABCD, 1'b0, 1'b0);
        #3;
        chk("s1 first stall", {31'b0, core_stall}, 32'd1);
        chk("s1 first addr", {2'b0, ic_addr}, 32'h0000_00C0);
        chk("s1 first inst", inst, NOP);
        tick();
        drive(1'b1, 32'h0000_0302, 32'h0, 1'b1, 1'b0);
        #3;
        chk("s1 second read", {31'b0, ic_read}, 32'd1);
        chk("s1 second addr", {2'b0, ic_addr}, 32'h0000_00C1);
        chk("s1 second stalled", {31'b0, core_stall}, 32'd1);
        tick();
        drive(1'b1, 32'h0000_0302, 32'hFFFF_0051, 1'b0, 1'b0);
        #3;
        chk("s1 done stall", {31'b0, core_stall}, 32'd0);
        chk("s1 done inst", inst, 32'h0051_0513);
        chk("s1 done inst_is_c", {31'b0, inst_is_c}, 32'd0);
        tick();
        drive(1'b0, 32'h0000_0302, 32'h0, 1'b1, 1'b0);
        #3;
        chk("s1 back to first", {31'b0, core_stall}, 32'd0);
        tick();

        // Straddle whose low half comes from the buffer (word 0xC1 holds 0xFFFF_0051)
        drive(1'b1, 32'h0000_0306, 32'h0, 1'b1, 1'b0);
        #3;
        chk("s2 first read", {31'b0, ic_read}, 32'd0);
        chk("s2 first stall", {31'b0, core_stall}, 32'd1);
        tick();
        #3;
        chk("s2 second read", {31'b0, ic_read}, 32'd1);
        chk("s2 second addr", {2'b0, ic_addr}, 32'h0000_00C2);
        tick();
        drive(1'b1, 32'h0000_0306, 32'h0000_1234, 1'b0, 1'b0);
        #3;
        chk("s2 done inst", inst, 32'h1234_FFFF);
        chk("s2 done stall", {31'b0, core_stall}, 32'd0);
        tick();

        // Address wrap at the top of memory
        drive(1'b1, 32'hFFFF_FFFE, 32'h0513_0000, 1'b0, 1'b0);
        #3;
        chk("s3 first addr", {2'b0, ic_addr}, 32'h3FFF_FFFF);
        chk("s3 first stall", {31'b0, core_stall}, 32'd1);
        tick();
        drive(1'b1, 32'hFFFF_FFFE, 32'h0000_0051, 1'b0, 1'b0);
        #3;
        chk("s3 wrap addr", {2'b0, ic_addr}, 32'd0);
        chk("s3 wrap read", {31'b0, ic_read}, 32'd1);
        chk("s3 wrap inst", inst, 32'h0051_0513);
        tick();

        // Reset while waiting in SECOND
        drive(1'b1, 32'h0000_0302, 32'h0513_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0302, 32'h0, 1'b1, 1'b0);
        #2;
        chk("s4 in second", {31'b0, ic_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s4 reset stall", {31'b0, core_stall}, 32'd1);
        chk("s4 reset read", {31'b0, ic_read}, 32'd0);
        chk("s4 reset addr", {2'b0, ic_addr}, 32'd0);
        chk("s4 reset inst", inst, NOP);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("s4 idle stall", {31'b0, core_stall}, 32'd1);
        chk("s4 idle read", {31'b0, ic_read}, 32'd0);
        tick();
        drive(1'b1, 32'h0000_0100, 32'h0041_4501, 1'b0, 1'b0);
        #3;
        chk("s4 fetch read", {31'b0, ic_read}, 32'd1);
        chk("s4 fetch inst", inst, 32'h0000_4501);
        chk("s4 fetch stall", {31'b0, core_stall}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
